// File: rtl/render_pkg.sv
// Shared state encoding, limits and width helper for the render frame scheduler.
package render_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LATCH     = 3'd1,
      ISSUE     = 3'd2,
      DRAIN     = 3'd3,
      WAIT_SWAP = 3'd4
   } sched_state_t;

   localparam int unsigned MISSED_MAX = 255;
   localparam int unsigned MISSED_W   = 8;

   // Column index width; never collapses to zero for a single-column screen.
   function automatic int unsigned col_width(input int unsigned num_columns);
      return (num_columns > 1) ? $clog2(num_columns) : 1;
   endfunction

endpackage

// File: rtl/render_frame_scheduler_if.sv
// Column request / completion channel between the frame scheduler (master) and the renderer (slave).
interface render_frame_scheduler_if #(
   parameter int unsigned NUM_COLUMNS = 320
);
   import render_pkg::*;

   localparam int unsigned COL_W = col_width(NUM_COLUMNS);

   logic             col_valid_out;
   logic [COL_W-1:0] col_out;
   logic             col_ready_in;
   logic             col_done_in;

   modport master (
      output col_valid_out,
      output col_out,
      input  col_ready_in,
      input  col_done_in
   );

   modport slave (
      input  col_valid_out,
      input  col_out,
      output col_ready_in,
      output col_done_in
   );

endinterface

// File: rtl/sched_outstanding_ctr.sv
// Issued-but-not-done column counter with issue-limit compare and underflow detect.
module sched_outstanding_ctr #(
   parameter  int unsigned MAX_OUTSTANDING = 4,
   localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             below_limit_c,
   output logic             underflow_c
);

   logic [CNT_W-1:0] count_d;

   // A completion with nothing outstanding is dropped so the count never wraps.
   always_comb begin
      count_d = count;
      if (inc && !dec) begin
         count_d = count + CNT_W'(1);
      end else if (dec && !inc && (count != '0)) begin
         count_d = count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         count <= count_d;
      end
   end

   assign below_limit_c = (count < CNT_W'(MAX_OUTSTANDING));
   assign underflow_c   = dec && !inc && (count == '0);

endmodule

// File: rtl/render_frame_scheduler.sv
// Frame-locked column issue sequencer with tear-free double-buffer swap.
// Optional RENDER_SCHED_STATS_EN adds the missed-frame counter and spurious-done error flag.
module render_frame_scheduler
   import render_pkg::*;
#(
   parameter int unsigned NUM_COLUMNS     = 320,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                     pixel_clk_in,
   input  logic                     rst_n_in,
   input  logic                     enable_in,
   input  logic                     very_last_pixel_in,
   render_frame_scheduler_if.master col_bus,
   output logic                     latch_state_out,
   output logic                     back_buf_sel_out,
   output logic                     swap_out,
   output logic                     busy_out,
   output logic                     err_out,
   output logic [MISSED_W-1:0]      missed_frames_out
);

   localparam int unsigned      COL_W    = col_width(NUM_COLUMNS);
   localparam int unsigned      CNT_W    = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLUMNS - 1);

   sched_state_t     state_q, state_d;
   logic [COL_W-1:0] col_q, col_d;
   logic             latch_d, swap_d, buf_d;
   logic [CNT_W-1:0] outstanding;
   logic             below_limit_c, underflow_c;
   logic             col_valid_c, transfer_c, final_done_c;
   logic             overrun_c, do_swap_c;

   sched_outstanding_ctr #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_outstanding (
      .clk           (pixel_clk_in),
      .rst_n         (rst_n_in),
      .inc           (transfer_c),
      .dec           (col_bus.col_done_in),
      .count         (outstanding),
      .below_limit_c (below_limit_c),
      .underflow_c   (underflow_c)
   );

   // Request valid depends only on registered state and count.
   assign col_valid_c  = (state_q == ISSUE) && below_limit_c;
   assign transfer_c   = col_valid_c && col_bus.col_ready_in;
   assign final_done_c = col_bus.col_done_in && (outstanding == CNT_W'(1));

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      latch_d   = 1'b0;
      swap_d    = 1'b0;
      buf_d     = back_buf_sel_out;
      overrun_c = 1'b0;
      do_swap_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (very_last_pixel_in && enable_in) begin
               state_d = LATCH;
               latch_d = 1'b1;
            end
         end
         LATCH: begin
            col_d     = '0;
            state_d   = ISSUE;
            overrun_c = very_last_pixel_in;
         end
         ISSUE: begin
            overrun_c = very_last_pixel_in;
            if (transfer_c) begin
               if (col_q == LAST_COL) begin
                  col_d   = '0;
                  state_d = DRAIN;
               end else begin
                  col_d = col_q + COL_W'(1);
               end
            end
         end
         DRAIN: begin
            // Last completion landing on the boundary still makes this frame.
            if (very_last_pixel_in && final_done_c) begin
               do_swap_c = 1'b1;
            end else begin
               overrun_c = very_last_pixel_in;
               if (outstanding == '0) begin
                  state_d = WAIT_SWAP;
               end
            end
         end
         WAIT_SWAP: begin
            do_swap_c = very_last_pixel_in;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (do_swap_c) begin
         swap_d  = 1'b1;
         buf_d   = ~back_buf_sel_out;
         latch_d = enable_in;
         state_d = enable_in ? LATCH : IDLE;
      end
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q          <= IDLE;
         col_q            <= '0;
         latch_state_out  <= 1'b0;
         swap_out         <= 1'b0;
         back_buf_sel_out <= 1'b0;
         busy_out         <= 1'b0;
      end else begin
         state_q          <= state_d;
         col_q            <= col_d;
         latch_state_out  <= latch_d;
         swap_out         <= swap_d;
         back_buf_sel_out <= buf_d;
         busy_out         <= (state_d != IDLE);
      end
   end

   assign col_bus.col_valid_out = col_valid_c;
   assign col_bus.col_out       = col_q;

`ifdef RENDER_SCHED_STATS_EN
   logic [MISSED_W-1:0] missed_q;
   logic                err_q;

   // Saturating overrun count and sticky spurious-completion flag.
   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         missed_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (overrun_c && (missed_q != MISSED_W'(MISSED_MAX))) begin
            missed_q <= missed_q + MISSED_W'(1);
         end
         if (underflow_c) begin
            err_q <= 1'b1;
         end
      end
   end

   assign missed_frames_out = missed_q;
   assign err_out           = err_q;
`else
   logic unused_stats_c;
   assign unused_stats_c    = overrun_c ^ underflow_c;
   assign missed_frames_out = '0;
   assign err_out           = 1'b0;
`endif

endmodule

// File: tb/tb_render_frame_scheduler.sv
// Self-checking bench for render_frame_scheduler: table-driven first frame plus scripted corner cases.
module tb_render_frame_scheduler;

   localparam int unsigned NUM_COLUMNS     = 4;
   localparam int unsigned MAX_OUTSTANDING = 2;
   localparam int          DONE_LAT        = 3;
`ifdef RENDER_SCHED_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic       pixel_clk_in = 1'b0;
   logic       rst_n_in;
   logic       enable_in;
   logic       very_last_pixel_in;
   logic       latch_state_out;
   logic       back_buf_sel_out;
   logic       swap_out;
   logic       busy_out;
   logic       err_out;
   logic [7:0] missed_frames_out;

   render_frame_scheduler_if #(.NUM_COLUMNS(NUM_COLUMNS)) col_bus ();

   render_frame_scheduler #(
      .NUM_COLUMNS     (NUM_COLUMNS),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) dut (
      .pixel_clk_in       (pixel_clk_in),
      .rst_n_in           (rst_n_in),
      .enable_in          (enable_in),
      .very_last_pixel_in (very_last_pixel_in),
      .col_bus            (col_bus),
      .latch_state_out    (latch_state_out),
      .back_buf_sel_out   (back_buf_sel_out),
      .swap_out           (swap_out),
      .busy_out           (busy_out),
      .err_out            (err_out),
      .missed_frames_out  (missed_frames_out)
   );

   always #5 pixel_clk_in = ~pixel_clk_in;

   typedef struct packed {
      logic       vlp;
      logic       en;
      logic       latch;
      logic       valid;
      logic [1:0] col;
      logic       swap;
      logic       bsel;
      logic       busy;
   } vec_t;

   vec_t vecs [15];
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   cyc          = 0;
   int   exp_col_q [$];
   int   due_q     [$];
   bit   ready_en  = 1'b1;
   bit   done_hold = 1'b0;

   function automatic vec_t mk(input logic vlp, en, latch, valid, input logic [1:0] col,
                               input logic swap, bsel, busy);
      return '{vlp, en, latch, valid, col, swap, bsel, busy};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_frame();
      for (int c = 0; c < int'(NUM_COLUMNS); c++) exp_col_q.push_back(c);
   endtask

   // One cycle: drive inputs at the falling edge, model the renderer, score any issued column.
   task automatic step(input logic vlp, input logic inj_done);
      @(negedge pixel_clk_in);
      cyc++;
      very_last_pixel_in   = vlp;
      col_bus.col_ready_in = ready_en;
      col_bus.col_done_in  = inj_done;
      if (!done_hold && (due_q.size() > 0) && (due_q[0] <= cyc)) begin
         void'(due_q.pop_front());
         col_bus.col_done_in = 1'b1;
      end
      if (col_bus.col_valid_out && col_bus.col_ready_in) begin
         if (exp_col_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL sb_unexpected_col: col %0d issued, none expected", col_bus.col_out);
         end else begin
            check("sb_col", 32'(col_bus.col_out), 32'(exp_col_q.pop_front()));
         end
         due_q.push_back(cyc + DONE_LAT);
      end
   endtask

   initial begin
      rst_n_in             = 1'b0;
      enable_in            = 1'b0;
      very_last_pixel_in   = 1'b0;
      col_bus.col_ready_in = 1'b0;
      col_bus.col_done_in  = 1'b0;

      //           vlp en latch valid col swap bsel busy
      vecs[0]  = mk(1, 1, 0, 0, 2'd0, 0, 0, 0);
      vecs[1]  = mk(0, 1, 1, 0, 2'd0, 0, 0, 1);
      vecs[2]  = mk(0, 1, 0, 1, 2'd0, 0, 0, 1);
      vecs[3]  = mk(0, 1, 0, 1, 2'd1, 0, 0, 1);
      vecs[4]  = mk(0, 1, 0, 0, 2'd2, 0, 0, 1);
      vecs[5]  = mk(0, 1, 0, 0, 2'd2, 0, 0, 1);
      vecs[6]  = mk(0, 1, 0, 1, 2'd2, 0, 0, 1);
      vecs[7]  = mk(0, 1, 0, 1, 2'd3, 0, 0, 1);
      vecs[8]  = mk(0, 0, 0, 0, 2'd0, 0, 0, 1);
      vecs[9]  = mk(0, 0, 0, 0, 2'd0, 0, 0, 1);
      vecs[10] = mk(0, 0, 0, 0, 2'd0, 0, 0, 1);
      vecs[11] = mk(0, 0, 0, 0, 2'd0, 0, 0, 1);
      vecs[12] = mk(1, 0, 0, 0, 2'd0, 0, 0, 1);
      vecs[13] = mk(0, 0, 0, 0, 2'd0, 1, 1, 0);
      vecs[14] = mk(0, 0, 0, 0, 2'd0, 0, 1, 0);

      repeat (2) @(negedge pixel_clk_in);
      check("reset_outputs", 32'({latch_state_out, col_bus.col_valid_out, col_bus.col_out, swap_out,
                                  back_buf_sel_out, busy_out, err_out, missed_frames_out}), 32'd0);
      rst_n_in = 1'b1;
      step(0, 0);

      // Frame 1: enable dropped during drain, so it swaps and returns to idle.
      push_frame();
      for (int i = 0; i < 15; i++) begin
         enable_in = vecs[i].en;
         step(vecs[i].vlp, 1'b0);
         check($sformatf("frame1_row%0d", i),
               32'({latch_state_out, col_bus.col_valid_out, col_bus.col_out, swap_out,
                    back_buf_sel_out, busy_out}),
               32'({vecs[i].latch, vecs[i].valid, vecs[i].col, vecs[i].swap,
                    vecs[i].bsel, vecs[i].busy}));
      end
      check("frame1_all_issued", 32'(exp_col_q.size()), 32'd0);
      check("frame1_stats_clear", 32'({err_out, missed_frames_out}), 32'd0);

      // Frame 2: renderer stalls, then a boundary lands mid-drain.
      enable_in = 1'b1;
      push_frame();
      ready_en = 1'b0;
      step(1, 0);
      step(0, 0);
      check("stall_latch", 32'(latch_state_out), 32'd1);
      for (int i = 0; i < 10; i++) begin
         step(0, 0);
         check($sformatf("stall_hold%0d", i), 32'({col_bus.col_valid_out, col_bus.col_out}),
               32'({1'b1, 2'd0}));
      end
      ready_en = 1'b1;
      repeat (8) step(0, 0);
      done_hold = 1'b1;
      step(1, 0);
      step(0, 0);
      check("overrun_missed", 32'(missed_frames_out), 32'(STATS));
      check("overrun_no_swap", 32'({swap_out, busy_out, back_buf_sel_out}), 32'({1'b0, 1'b1, 1'b1}));
      done_hold = 1'b0;
      step(0, 0);
      step(0, 0);
      push_frame();
      step(1, 0);
      step(0, 0);
      check("late_swap", 32'({swap_out, back_buf_sel_out, latch_state_out}), 32'({1'b1, 1'b0, 1'b1}));
      check("late_swap_missed", 32'(missed_frames_out), 32'(STATS));

      // Frame 3: final completion coincides with the boundary.
      repeat (8) step(0, 0);
      push_frame();
      step(1, 0);
      step(0, 0);
      check("coincident_swap", 32'({swap_out, back_buf_sel_out, latch_state_out, busy_out}),
            32'({1'b1, 1'b1, 1'b1, 1'b1}));
      check("coincident_no_overrun", 32'(missed_frames_out), 32'(STATS));

      // Frame 4: reset while column 2 is pending.
      repeat (3) step(0, 0);
      check("pre_reset_col", 32'(col_bus.col_out), 32'd2);
      rst_n_in = 1'b0;
      #1;
      check("reset_async", 32'({latch_state_out, col_bus.col_valid_out, col_bus.col_out, swap_out,
                                back_buf_sel_out, busy_out, err_out, missed_frames_out}), 32'd0);
      exp_col_q.delete();
      due_q.delete();
      repeat (2) step(0, 0);
      rst_n_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(0, 0);
         check($sformatf("post_reset_idle%0d", i),
               32'({col_bus.col_valid_out, latch_state_out, busy_out, swap_out, err_out}), 32'd0);
      end

      // Spurious completion in idle.
      step(0, 1);
      step(0, 0);
      check("spurious_err", 32'(err_out), 32'(STATS));
      check("spurious_idle", 32'({col_bus.col_valid_out, busy_out}), 32'd0);

      // Counter must still read zero: a fresh frame issues at once and completes.
      push_frame();
      step(1, 0);
      step(0, 0);
      check("post_err_latch", 32'(latch_state_out), 32'd1);
      step(0, 0);
      check("post_err_issue", 32'({col_bus.col_valid_out, col_bus.col_out}), 32'({1'b1, 2'd0}));
      repeat (9) step(0, 0);
      check("post_err_all_issued", 32'(exp_col_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/render_frame_scheduler.md
# render_frame_scheduler

Sequences the raycaster column renderer against the video timing generator: on each frame boundary it latches player state, issues every screen column to the renderer through a valid/ready handshake, tracks outstanding columns, and swaps the double-buffered framebuffer only at a frame boundary so the display never tears. It sits between the video timing generator (frame pulses) and the raycaster/framebuffer datapath, in the pixel clock domain.

## Interface
- NUM_COLUMNS, 320: columns rendered per frame.
- MAX_OUTSTANDING, 4: maximum issued-but-not-done columns.
- pixel_clk_in  input  1  pixel clock; all logic on rising edge.
- rst_n_in  input  1  reset, asynchronous, active-low.
- enable_in  input  1  run request; sampled only at frame start.
- very_last_pixel_in  input  1  one-cycle pulse from timing generator at the last pixel of the frame.
- col_valid_out  output  1  column request valid.
- col_out  output  $clog2(NUM_COLUMNS)  column index to render.
- col_ready_in  input  1  renderer accepts request.
- col_done_in  input  1  one-cycle pulse: one column written to the back buffer.
- latch_state_out  output  1  one-cycle pulse: snapshot player position/angle for this frame.
- back_buf_sel_out  output  1  buffer being rendered; the display reads ~back_buf_sel_out.
- swap_out  output  1  one-cycle pulse in the cycle the buffer select toggles.
- busy_out  output  1  high in any state other than IDLE.
- err_out  output  1  sticky: col_done_in arrived with zero outstanding.
- missed_frames_out  output  8  saturating count of frame boundaries that found the render unfinished.

## Operation
- States: IDLE, LATCH, ISSUE, DRAIN, WAIT_SWAP.
- IDLE: on very_last_pixel_in with enable_in=1 -> LATCH.
- LATCH: one cycle, latch_state_out=1, col_out<=0 -> ISSUE.
- ISSUE: col_valid_out = (outstanding < MAX_OUTSTANDING). A transfer is col_valid_out & col_ready_in. It increments col_out. The transfer of column NUM_COLUMNS-1 -> DRAIN.
- Outstanding counter: +1 on transfer, -1 on col_done_in, unchanged when both occur in the same cycle. Width $clog2(MAX_OUTSTANDING+1).
- DRAIN: wait for outstanding==0 -> WAIT_SWAP.
- WAIT_SWAP: on very_last_pixel_in:
  - toggle back_buf_sel_out and pulse swap_out.
  - enable_in=1 -> LATCH; enable_in=0 -> IDLE.
- Overrun: very_last_pixel_in while in LATCH, ISSUE or DRAIN.
  - missed_frames_out increments, saturating at 255.
  - No swap; rendering continues; the swap waits for the next boundary.
- Simultaneous events in DRAIN: if the final col_done_in (outstanding 1->0) coincides with very_last_pixel_in, swap in that same cycle, go to LATCH/IDLE directly, no overrun counted.
- col_done_in with outstanding==0: ignored, counter stays 0, err_out<=1 until reset.
- enable_in deasserted mid-frame: the current frame completes and swaps, then IDLE.
- Reset mid-frame: everything returns to reset values immediately; any in-flight col_done_in after reset release is treated as spurious (sets err_out).

## Timing
- Reset values: state IDLE, all outputs 0, back_buf_sel_out=0, outstanding=0.
- All outputs registered except col_valid_out, which is combinational from state and outstanding registers only (no input-to-output path).
- very_last_pixel_in at cycle t in IDLE: latch_state_out high at t+1, first col_valid_out at t+2.
- Peak throughput in ISSUE: one column per cycle.
- swap_out is asserted in the cycle after the very_last_pixel_in edge that triggered it, coincident with the new back_buf_sel_out value.

## Configuration
- RENDER_SCHED_STATS_EN defined: missed_frames_out counter and err_out tracking are implemented.
- Not defined: missed_frames_out and err_out are tied 0, no counter flops. Sequencing behaviour is identical.

## Structure
- render_pkg holds:
  - the sched_state_t enum (IDLE, LATCH, ISSUE, DRAIN, WAIT_SWAP);
  - the MISSED_MAX=255 localparam;
  - a shared column-index width function.
- One sub-module, sched_outstanding_ctr: up/down counter with limit compare and underflow flag. It is instantiated once.

## Test plan
Bench parameters: NUM_COLUMNS=4, MAX_OUTSTANDING=2.
- Reset, enable_in=1, ready always 1, done 3 cycles after each issue, pulse very_last_pixel_in -> latch pulse, cols 0,1 issued, stall at outstanding 2, cols 2,3 follow dones; next boundary -> swap_out=1, back_buf_sel_out=1.
- Hold col_ready_in=0 for 10 cycles in ISSUE -> col_valid_out stays 1, col_out holds 0, outstanding stays 0.
- Second very_last_pixel_in while DRAIN has outstanding=1 -> missed_frames_out=1, no swap; swap at the following boundary after drain.
- Final col_done_in in the same cycle as very_last_pixel_in -> swap next cycle, missed_frames_out unchanged, LATCH follows.
- col_done_in pulse in IDLE -> err_out=1, outstanding stays 0; with RENDER_SCHED_STATS_EN undefined -> err_out stays 0.
- Assert rst_n_in low mid-ISSUE (col_out=2) -> all outputs 0 asynchronously; after release, no activity until the next very_last_pixel_in.
